adc_avg_filter: RTL

- Boxcar moving-average filter on the ADC sample stream. It sits directly downstream of the SPI ADC master and takes each completed 8-bit conversion with a one-cycle valid strobe.
- Outputs the mean of the last 2^LOG2_DEPTH samples, with a valid strobe, to the counter/display path.
- Smooths conversion noise so the displayed level does not flicker between adjacent codes.

---
 rtl/adc_avg_filter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/adc_avg_filter.sv
// adc_avg_filter: boxcar moving average over the last 2^LOG2_DEPTH ADC samples.
// The window buffer, running sum and output stage are all in this one file.
// Optional build macro: ADC_AVG_ROUND_EN selects round-half-up with saturation
// for the output divide. When it is not defined, the divide truncates.
module adc_avg_filter #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,      // active-high synchronous reset
    input  logic                  din_valid,
    input  logic [DATA_W-1:0]     din,
    input  logic                  clear,
    output logic                  dout_valid,
    output logic [DATA_W-1:0]     dout,
    output logic [LOG2_DEPTH:0]   fill,
    output logic                  full
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;

    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = 1;
    localparam logic [LOG2_DEPTH:0]   FILL_ONE = 1;
    localparam logic [LOG2_DEPTH:0]   FILL_MAX = (LOG2_DEPTH+1)'(DEPTH);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Control and datapath state
    state_t                  state_reg,      state_next;
    logic [LOG2_DEPTH-1:0]   wr_ptr_reg,     wr_ptr_next;
    logic [SUM_W-1:0]        sum_reg,        sum_next;
    logic [LOG2_DEPTH:0]     fill_reg,       fill_next;
    logic                    full_reg,       full_next;
    logic                    upd_reg,        upd_next;
    logic [DATA_W-1:0]       dout_reg,       dout_next;
    logic                    dout_valid_reg, dout_valid_next;

    // Window storage: registered read, prefetching the oldest sample
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DATA_W-1:0]       rd_data_reg;
    logic                    mem_we;

    // Helper values
    logic [DATA_W-1:0]       sub_term;
    logic [DATA_W-1:0]       avg_value;

    // A sample is taken only when neither clear nor reset overrides it
    assign mem_we = din_valid & ~clear & ~n_rst;

    // Average of the current running sum
`ifdef ADC_AVG_ROUND_EN
    logic [SUM_W:0]          sum_rounded;
    logic [DATA_W:0]         avg_wide;

    // Round half up; one extra bit catches a carry out so it can saturate
    always_comb begin
        sum_rounded = {1'b0, sum_reg} + (SUM_W+1)'(DEPTH / 2);
        avg_wide    = sum_rounded[SUM_W:LOG2_DEPTH];
        avg_value   = avg_wide[DATA_W] ? {DATA_W{1'b1}} : avg_wide[DATA_W-1:0];
    end
`else
    // Truncating divide by the window length
    always_comb begin
        avg_value = sum_reg[SUM_W-1:LOG2_DEPTH];
    end
`endif

    // Next-state, running sum, fill tracking and output-stage logic
    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        sum_next        = sum_reg;
        fill_next       = fill_reg;
        full_next       = full_reg;
        upd_next        = 1'b0;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        sub_term        = '0;

        // Output stage: publish the sum that was updated in the previous cycle
        if (upd_reg && (state_reg == ST_RUN)) begin
            dout_next       = avg_value;
            dout_valid_next = 1'b1;
        end

        if (clear) begin
            // Flush the window; dout keeps its last value, pending strobe dropped
            state_next      = ST_FILL;
            wr_ptr_next     = '0;
            sum_next        = '0;
            fill_next       = '0;
            full_next       = 1'b0;
            dout_next       = dout_reg;
            dout_valid_next = 1'b0;
        end else if (din_valid) begin
            // The oldest sample leaves the window only once it is full
            sub_term    = (state_reg == ST_RUN) ? rd_data_reg : '0;
            sum_next    = sum_reg + {{LOG2_DEPTH{1'b0}}, din}
                                  - {{LOG2_DEPTH{1'b0}}, sub_term};
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            upd_next    = 1'b1;

            case (state_reg)
                ST_FILL: begin
                    fill_next = fill_reg + FILL_ONE;
                    if (fill_reg == FILL_MAX - FILL_ONE) begin
                        state_next = ST_RUN;
                        full_next  = 1'b1;
                    end
                end
                ST_RUN: begin
                    fill_next = FILL_MAX;
                    full_next = 1'b1;
                end
                default: begin
                    state_next = ST_FILL;
                end
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_reg      <= ST_FILL;
            wr_ptr_reg     <= '0;
            sum_reg        <= '0;
            fill_reg       <= '0;
            full_reg       <= 1'b0;
            upd_reg        <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            sum_reg        <= sum_next;
            fill_reg       <= fill_next;
            full_reg       <= full_next;
            upd_reg        <= upd_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
        end
    end

    // Buffer write at wr_ptr; read the slot the next sample will overwrite.
    // Read and write addresses never coincide while a write happens, because
    // the read address is the incremented pointer whenever a write occurs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= din;
        end
        rd_data_reg <= mem[wr_ptr_next];
    end

    assign dout_valid = dout_valid_reg;
    assign dout       = dout_reg;
    assign fill       = fill_reg;
    assign full       = full_reg;

endmodule
